// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx
// PS/2 host-to-device transmitter. It sends one command byte to the device
// over the shared open-drain PS2Clk/PS2Data lines.
// Sequence: inhibit the clock, request-to-send, shift out 8 data bits, odd
// parity and stop on device-generated clock falling edges, then check the
// device ACK.
//
// Ports
//   clk, rst_n     system clock; asynchronous active-low reset
//   tx_valid       byte request, accepted when tx_valid && tx_ready
//   tx_data[7:0]   command byte, sampled on accept
//   tx_ready       high only while idle and not pulsing done/err
//   ps2_clk_in     PS2Clk pad input (asynchronous)
//   ps2_data_in    PS2Data pad input (asynchronous)
//   ps2_clk_oe     1 = pull PS2Clk low
//   ps2_data_oe    1 = pull PS2Data low
//   busy           high in every state except IDLE
//   tx_done        1-cycle pulse: byte sent and ACKed by the device
//   tx_err         1-cycle pulse: NACK or timeout
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 11000,
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_XFER, S_ACK, S_WAIT_IDLE
  } state_e;

  localparam int INH_W = $clog2(INHIBIT_CYCLES);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES);
  localparam logic [INH_W-1:0] INH_LOAD  = INH_W'(INHIBIT_CYCLES - 1);
  // Data is pulled low during the last 16 inhibit cycles, so it is already
  // low when the clock is released (request-to-send).
  localparam logic [INH_W-1:0] DATA_LEAD = INH_W'(16);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic [9:0]             frame_q, frame_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [INH_W-1:0]       inh_cnt_q, inh_cnt_d;
  logic [TO_W-1:0]        to_cnt_q, to_cnt_d;
  logic                   bit_oe_q, bit_oe_d;
  logic                   clk_oe_q, clk_oe_d;
  logic                   data_oe_q, data_oe_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic clk_s, data_s, fe, timed;

  // Synchronisers reset to 1 (idle bus) so no falling edge appears after reset.
  assign clk_sync_d  = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_in};
  assign data_sync_d = {data_sync_q[SYNC_STAGES-2:0], ps2_data_in};
  assign clk_s       = clk_sync_q[SYNC_STAGES-1];
  assign data_s      = data_sync_q[SYNC_STAGES-1];
  assign clk_prev_d  = clk_s;
  assign fe          = clk_prev_q & ~clk_s;
  assign timed       = state_q inside {S_REQ, S_XFER, S_ACK, S_WAIT_IDLE};

  assign tx_ready    = (state_q == S_IDLE) && !done_q && !err_q;
  assign busy        = (state_q != S_IDLE);
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign tx_done     = done_q;
  assign tx_err      = err_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    state_d   = state_q;
    frame_d   = frame_q;
    bit_cnt_d = bit_cnt_q;
    inh_cnt_d = inh_cnt_q;
    bit_oe_d  = bit_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (tx_valid && tx_ready) begin
          // Stop bit, then parity chosen so the 9 data+parity bits are odd.
          frame_d   = {1'b1, ~^tx_data, tx_data};
          inh_cnt_d = INH_LOAD;
          state_d   = S_INHIBIT;
        end
      end
      S_INHIBIT: begin
        if (inh_cnt_q == '0) state_d = S_REQ;
        else                 inh_cnt_d = inh_cnt_q - INH_W'(1);
      end
      S_REQ: begin
        if (fe) begin
          bit_oe_d  = ~frame_q[0];
          bit_cnt_d = 4'd1;
          state_d   = S_XFER;
        end
      end
      S_XFER: begin
        // Bits change only on a device falling edge, i.e. while its clock is low.
        if (fe) begin
          if (bit_cnt_q == 4'd9) begin
            bit_oe_d = 1'b0;
            state_d  = S_ACK;
          end else begin
            bit_oe_d  = ~frame_q[bit_cnt_q];
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      S_ACK: begin
        if (fe) begin
          if (data_s) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_WAIT_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The device went silent: abandon the frame and release the bus.
    if (timed && !fe && (state_d == state_q) && (to_cnt_q == TO_LAST)) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
    end

    to_cnt_d = (!timed || fe || (state_d != state_q)) ? '0 : to_cnt_q + TO_W'(1);

    // Line enables are registered from the next state so the pads never see
    // decode glitches.
    clk_oe_d  = (state_d == S_INHIBIT);
    data_oe_d = ((state_d == S_INHIBIT) && (inh_cnt_d < DATA_LEAD)) ||
                (state_d == S_REQ) ||
                ((state_d == S_XFER) && bit_oe_d);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      clk_sync_q  <= '1;
      data_sync_q <= '1;
      clk_prev_q  <= 1'b1;
      frame_q     <= '0;
      bit_cnt_q   <= '0;
      inh_cnt_q   <= '0;
      to_cnt_q    <= '0;
      bit_oe_q    <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      frame_q     <= frame_d;
      bit_cnt_q   <= bit_cnt_d;
      inh_cnt_q   <= inh_cnt_d;
      to_cnt_q    <= to_cnt_d;
      bit_oe_q    <= bit_oe_d;
      clk_oe_q    <= clk_oe_d;
      data_oe_q   <= data_oe_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// Testbench for ps2_host_tx: a PS/2 device model clocks frames out of the
// host, and each scenario task checks the sampled bits and pulses against
// a frame model computed from the byte.
module tb_ps2_host_tx;

  localparam int INH = 64;
  localparam int TO  = 2000;
  localparam int H   = 20;   // device clock half period, in clk cycles

  logic       clk = 1'b0;
  logic       rst_n;
  logic       tx_valid, tx_ready;
  logic [7:0] tx_data;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       busy, tx_done, tx_err;
  logic       dev_clk_low, dev_data_low;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0, err_cnt = 0, pulse_viol = 0, tog_viol = 0;
  logic prev_pulse = 1'b0, prev_data_oe = 1'b0, tog_en = 1'b0;

  always #5 clk = ~clk;

  // Open-drain wired-AND lines with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_data(tx_data),
    .tx_ready(tx_ready), .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
    .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe), .busy(busy),
    .tx_done(tx_done), .tx_err(tx_err)
  );

  // Pulse monitor: counts pulses and flags any pulse property violation.
  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err)  err_cnt  <= err_cnt + 1;
    if ((tx_done || tx_err) &&
        ((tx_done && tx_err) || prev_pulse || ps2_clk_oe || ps2_data_oe || busy || tx_ready))
      pulse_viol <= pulse_viol + 1;
    if (prev_pulse && !tx_done && !tx_err && rst_n && !tx_ready)
      pulse_viol <= pulse_viol + 1;
    prev_pulse <= tx_done | tx_err;
    if (tog_en && (ps2_data_oe !== prev_data_oe) && ps2_clk_in)
      tog_viol <= tog_viol + 1;
    prev_data_oe <= ps2_data_oe;
  end

  // Reference frame as the device sees it: got[0]=start ... got[10]=stop.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic par;
    par = ($countones(b) % 2 == 0);
    return {1'b1, par, b, 1'b0};
  endfunction

  task automatic host_send(input logic [7:0] b);
    @(negedge clk);
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < 1000 && !tx_ready; i++) @(negedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Device: waits for the request, samples start, then clocks nbits bits and
  // samples each on the rising edge. With all 10 bits it adds the ACK clock.
  task automatic dev_run(input int nbits, input bit ack,
                         output logic [10:0] got, output bit ok);
    got = '0;
    ok  = 1'b0;
    for (int i = 0; i < 5000 && !ps2_clk_oe; i++) @(negedge clk);
    if (!ps2_clk_oe) return;
    for (int i = 0; i < 5000 && ps2_clk_oe; i++) @(negedge clk);
    if (ps2_clk_oe) return;
    ok = 1'b1;
    got[0] = ps2_data_in;
    repeat (H) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      dev_clk_low = 1'b1;
      repeat (H) @(negedge clk);
      dev_clk_low = 1'b0;
      got[i+1] = ps2_data_in;
      repeat (H) @(negedge clk);
    end
    if (nbits < 10) return;
    dev_data_low = ack;
    repeat (2) @(negedge clk);
    dev_clk_low = 1'b1;
    repeat (H) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (2) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic run_frame(input logic [7:0] b, input bit ack,
                           output logic [10:0] got, output bit ok,
                           output int dd, output int de);
    int d0, e0;
    d0 = done_cnt;
    e0 = err_cnt;
    fork
      host_send(b);
      dev_run(10, ack, got, ok);
    join
    for (int i = 0; i < 300 && done_cnt == d0 && err_cnt == e0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    dd = done_cnt - d0;
    de = err_cnt - e0;
  endtask

  task automatic test_reset;
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin bad++; $display("FAIL reset_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    total++; if ({tx_done, tx_err} !== 2'b00) begin bad++; $display("FAIL reset_pulses: got %b want 00", {tx_done, tx_err}); end
  endtask

  task automatic test_send_f4;
    logic [10:0] got; bit ok; int dd, de;
    run_frame(8'hF4, 1'b1, got, ok, dd, de);
    total++; if (!ok) begin bad++; $display("FAIL f4_request: no request seen"); end
    total++; if (got !== 11'b1_0_11110100_0) begin bad++; $display("FAIL f4_frame: got %b want %b", got, 11'b1_0_11110100_0); end
    total++; if (dd !== 1 || de !== 0) begin bad++; $display("FAIL f4_pulses: done=%0d err=%0d want 1/0", dd, de); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL f4_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_parity;
    logic [7:0] bytes [2];
    logic [10:0] got; bit ok; int dd, de;
    bytes[0] = 8'hFF;
    bytes[1] = 8'h00;
    tog_en = 1'b1;
    for (int k = 0; k < 2; k++) begin
      run_frame(bytes[k], 1'b1, got, ok, dd, de);
      total++; if (got[9] !== 1'b1) begin bad++; $display("FAIL parity_%h: got %b want 1", bytes[k], got[9]); end
      total++; if (got !== model_frame(bytes[k]) || !ok) begin bad++; $display("FAIL frame_%h: got %b want %b", bytes[k], got, model_frame(bytes[k])); end
      total++; if (dd !== 1 || de !== 0) begin bad++; $display("FAIL pulses_%h: done=%0d err=%0d want 1/0", bytes[k], dd, de); end
    end
    tog_en = 1'b0;
    total++; if (tog_viol !== 0) begin bad++; $display("FAIL data_toggle_clk_high: got %0d want 0", tog_viol); end
  endtask

  task automatic test_inhibit;
    logic [10:0] got; bit ok; int hi, d_first, d0;
    hi = 0; d_first = -1; d0 = done_cnt;
    fork
      host_send(8'($urandom));
      dev_run(10, 1'b1, got, ok);
      begin
        for (int i = 0; i < 5000; i++) begin
          @(negedge clk);
          if (ps2_clk_oe) begin
            hi++;
            if (ps2_data_oe && d_first < 0) d_first = hi;
          end else if (hi > 0) break;
        end
      end
    join
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
    total++; if (hi !== INH) begin bad++; $display("FAIL inhibit_len: got %0d want %0d", hi, INH); end
    total++; if (hi - d_first + 1 !== 16) begin bad++; $display("FAIL data_lead: got %0d want 16", hi - d_first + 1); end
  endtask

  task automatic test_nack;
    logic [10:0] got; bit ok; int dd, de, e0;
    logic [2:0] at_err;
    e0 = err_cnt; at_err = 3'b111;
    fork
      run_frame(8'hF5, 1'b0, got, ok, dd, de);
      begin
        for (int i = 0; i < 5000 && !tx_err; i++) @(negedge clk);
        at_err = {ps2_clk_oe, ps2_data_oe, busy};
      end
    join
    total++; if (dd !== 0 || de !== 1) begin bad++; $display("FAIL nack_pulses: done=%0d err=%0d want 0/1", dd, de); end
    total++; if (at_err !== 3'b000) begin bad++; $display("FAIL nack_idle: oe/oe/busy got %b want 000", at_err); end
  endtask

  task automatic test_timeout;
    int c; logic [1:0] oe_at;
    c = -1; oe_at = 2'b11;
    fork
      host_send(8'h3C);
      begin
        for (int i = 0; i < 5000 && !ps2_clk_oe; i++) @(negedge clk);
        for (int i = 0; i < 5000 && ps2_clk_oe; i++) @(negedge clk);
        c = 0;
        for (int i = 0; i < 3 * TO && !tx_err; i++) begin
          @(negedge clk);
          c++;
        end
        oe_at = {ps2_clk_oe, ps2_data_oe};
      end
    join
    total++; if (c !== TO || !tx_err) begin bad++; $display("FAIL timeout_latency: got %0d want %0d", c, TO); end
    total++; if (oe_at !== 2'b00) begin bad++; $display("FAIL timeout_release: got %b want 00", oe_at); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid_frame;
    logic [10:0] got; bit ok; int dd, de, extra_hi, d0;
    fork
      host_send(8'hF4);
      dev_run(4, 1'b1, got, ok);
    join
    @(negedge clk);
    // F4 bit 3 is 0, so the host is pulling data low right now.
    total++; if (ps2_data_oe !== 1'b1) begin bad++; $display("FAIL pre_reset_drive: got %b want 1", ps2_data_oe); end
    rst_n = 1'b0;
    #1;
    total++; if ({ps2_clk_oe, ps2_data_oe} !== 2'b00) begin bad++; $display("FAIL async_release: got %b want 00", {ps2_clk_oe, ps2_data_oe}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL post_reset_idle: ready=%b busy=%b want 1/0", tx_ready, busy); end
    d0 = done_cnt;
    fork
      host_send(8'hF4);
      dev_run(10, 1'b1, got, ok);
      begin
        for (int i = 0; i < 5000 && !busy; i++) @(negedge clk);
        repeat (30) @(negedge clk);
        tx_data  = 8'hAA;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    dd = done_cnt - d0;
    total++; if (got !== model_frame(8'hF4) || !ok) begin bad++; $display("FAIL after_reset_frame: got %b want %b", got, model_frame(8'hF4)); end
    total++; if (dd !== 1) begin bad++; $display("FAIL after_reset_done: got %0d want 1", dd); end
    extra_hi = 0;
    for (int i = 0; i < 3 * INH; i++) begin
      @(negedge clk);
      if (ps2_clk_oe) extra_hi++;
    end
    total++; if (extra_hi !== 0) begin bad++; $display("FAIL no_queued_frame: clk_oe high %0d cycles want 0", extra_hi); end
  endtask

  task automatic test_random;
    logic [10:0] got; bit ok; int dd, de;
    logic [7:0] b; bit ack;
    tog_en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      b   = 8'($urandom);
      ack = ($urandom_range(0, 3) != 0);
      run_frame(b, ack, got, ok, dd, de);
      total++; if (got !== model_frame(b) || !ok) begin bad++; $display("FAIL rand_frame_%0d: byte %h got %b want %b", k, b, got, model_frame(b)); end
      total++; if (dd !== int'(ack) || de !== int'(!ack)) begin bad++; $display("FAIL rand_pulses_%0d: done=%0d err=%0d ack=%b", k, dd, de, ack); end
    end
    tog_en = 1'b0;
    total++; if (tog_viol !== 0) begin bad++; $display("FAIL rand_data_toggle: got %0d want 0", tog_viol); end
  endtask

  initial begin
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0;
    dev_clk_low = 1'b0; dev_data_low = 1'b0;
    repeat (4) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_send_f4;
    test_parity;
    test_inhibit;
    test_nack;
    test_timeout;
    test_reset_mid_frame;
    test_random;
    total++; if (pulse_viol !== 0) begin bad++; $display("FAIL pulse_rules: got %0d violations want 0", pulse_viol); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
